// File: rtl/isa_pkg.sv
// Shared definitions for the 14-bit ISA datapath: widths, instruction fields
// and the fetch state encoding.
package isa_pkg;

    localparam int unsigned ISA_ADDR_W = 5;
    localparam int unsigned ISA_DATA_W = 14;

    // Instruction word layout used by decode.
    localparam int unsigned OPCODE_MSB  = 13;
    localparam int unsigned OPCODE_LSB  = 10;
    localparam int unsigned OPCODE_W    = OPCODE_MSB - OPCODE_LSB + 1;
    localparam int unsigned OPERAND_MSB = 9;
    localparam int unsigned OPERAND_LSB = 0;
    localparam int unsigned OPERAND_W   = OPERAND_MSB - OPERAND_LSB + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        WAIT  = 2'd2,
        VALID = 2'd3
    } fetch_state_t;

    function automatic logic [OPCODE_W-1:0] opcode_of(input logic [ISA_DATA_W-1:0] word);
        return word[OPCODE_MSB:OPCODE_LSB];
    endfunction

    function automatic logic [OPERAND_W-1:0] operand_of(input logic [ISA_DATA_W-1:0] word);
        return word[OPERAND_MSB:OPERAND_LSB];
    endfunction

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, reads program memory one word at a
// time and hands each word to decode over a valid/ready handshake.
module fetch_unit
    import isa_pkg::*;
#(
    parameter int unsigned       ADDR_W   = ISA_ADDR_W,
    parameter int unsigned       DATA_W   = ISA_DATA_W,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [ADDR_W-1:0] mem_add,
    output logic              mem_en,
    input  logic [DATA_W-1:0] mem_data,
    output logic              instr_valid,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc,
    input  logic              instr_ready
);

    fetch_state_t      state;
    fetch_state_t      state_n;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_n;
    logic              mem_en_n;
    logic [ADDR_W-1:0] mem_add_n;
    logic              instr_valid_n;
    logic              capture;

    // State and PC register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            pc    <= RESET_PC;
        end else begin
            state <= state_n;
            pc    <= pc_n;
        end
    end

    // Next state and PC; a redirect overrides every other transition.
    always_comb begin
        state_n = state;
        pc_n    = pc;
        if (redirect_valid) begin
            pc_n    = redirect_pc;
            state_n = run ? REQ : IDLE;
        end else begin
            unique case (state)
                IDLE:    if (run) state_n = REQ;
                REQ:     state_n = WAIT;
                WAIT:    state_n = VALID;
                VALID: begin
                    if (instr_valid && instr_ready) begin
                        pc_n    = pc + ADDR_W'(1);
                        state_n = run ? REQ : IDLE;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // Output decode from the upcoming state so the registered outputs track it.
    always_comb begin
        mem_en_n      = (state_n == REQ);
        mem_add_n     = pc_n;
        instr_valid_n = (state_n == VALID);
        capture       = (state == WAIT) && !redirect_valid;
    end

    // Registered outputs; the word is only captured when no redirect kills it.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_en      <= 1'b0;
            mem_add     <= RESET_PC;
            instr_valid <= 1'b0;
            instr       <= '0;
            instr_pc    <= '0;
        end else begin
            mem_en      <= mem_en_n;
            mem_add     <= mem_add_n;
            instr_valid <= instr_valid_n;
            if (capture) begin
                instr    <= mem_data;
                instr_pc <= pc;
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit with a synchronous-read program memory model.
module tb_fetch_unit;

    typedef struct packed {
        logic [4:0]  pc;
        logic [13:0] word;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        run;
    logic        redirect_valid;
    logic [4:0]  redirect_pc;
    logic [4:0]  mem_add;
    logic        mem_en;
    logic [13:0] mem_data;
    logic        instr_valid;
    logic [13:0] instr;
    logic [4:0]  instr_pc;
    logic        instr_ready;

    logic [13:0] mem [32];
    exp_t        exp_q [$];
    int          xfer_cyc [$];
    int          cyc;
    int          n_checks;
    int          n_errors;

    fetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .run            (run),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .mem_add        (mem_add),
        .mem_en         (mem_en),
        .mem_data       (mem_data),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_ready    (instr_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Program memory: data valid the cycle after an enabled read.
    always @(posedge clk) if (mem_en) mem_data <= mem[mem_add];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Every transfer pops the next expected word.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && instr_valid && instr_ready) begin
            if (exp_q.size() == 0) begin
                check("xfer_unexpected", 32'(instr_pc), 32'hFFFF);
            end else begin
                e = exp_q.pop_front();
                check("instr", 32'(instr), 32'(e.word));
                check("instr_pc", 32'(instr_pc), 32'(e.pc));
                xfer_cyc.push_back(cyc);
            end
        end
    end

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_exp(input int a);
        exp_t e;
        e.pc   = 5'(a);
        e.word = 14'(14'h1000 + a);
        exp_q.push_back(e);
    endtask

    task automatic wait_req(input int a, input string tag);
        bit seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            tick();
            if (mem_en && mem_add == 5'(a)) seen = 1;
        end
        check(tag, 32'(seen), 32'd1);
    endtask

    task automatic wait_valid(input string tag);
        bit seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            tick();
            if (instr_valid) seen = 1;
        end
        check(tag, 32'(seen), 32'd1);
    endtask

    task automatic wait_empty(input string tag);
        for (int i = 0; i < 60 && exp_q.size() != 0; i++) tick();
        check(tag, 32'(exp_q.size()), 32'd0);
        tick(2);
    endtask

    initial begin
        int en_cnt;
        int x0;
        cyc = 0;
        n_checks = 0;
        n_errors = 0;
        for (int k = 0; k < 32; k++) mem[k] = 14'(14'h1000 + k);
        mem_data       = '0;
        rst            = 1'b1;
        run            = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        instr_ready    = 1'b0;
        tick(2);
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_en", 32'(mem_en), 32'd0);
        check("rst_add", 32'(mem_add), 32'd0);
        check("rst_instr", 32'(instr), 32'd0);
        check("rst_ipc", 32'(instr_pc), 32'd0);
        rst = 1'b0;
        tick();

        // Straight-line fetch of words 0..2, dropping run during the last REQ.
        x0 = xfer_cyc.size();
        push_exp(0); push_exp(1); push_exp(2);
        run = 1'b1;
        instr_ready = 1'b1;
        tick();
        check("req_en", 32'(mem_en), 32'd1);
        check("req_add", 32'(mem_add), 32'd0);
        tick();
        check("wait_en", 32'(mem_en), 32'd0);
        check("wait_valid", 32'(instr_valid), 32'd0);
        tick();
        check("lat3_valid", 32'(instr_valid), 32'd1);
        wait_req(2, "req_pc2");
        run = 1'b0;
        wait_empty("drain_run");
        if (xfer_cyc.size() >= x0 + 3) begin
            check("gap01", 32'(xfer_cyc[x0+1] - xfer_cyc[x0]), 32'd3);
            check("gap12", 32'(xfer_cyc[x0+2] - xfer_cyc[x0+1]), 32'd3);
        end else begin
            check("xfer_count", 32'(xfer_cyc.size() - x0), 32'd3);
        end
        en_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (mem_en) en_cnt++;
        end
        check("idle_no_en", 32'(en_cnt), 32'd0);
        check("idle_valid", 32'(instr_valid), 32'd0);

        // Backpressure on word 3, resuming at pc+1.
        push_exp(3); push_exp(4);
        instr_ready = 1'b0;
        run = 1'b1;
        wait_valid("bp_valid");
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_instr", 32'(instr), 32'h1003);
            check("bp_en", 32'(mem_en), 32'd0);
        end
        instr_ready = 1'b1;
        tick();
        check("bp_next_en", 32'(mem_en), 32'd1);
        check("bp_next_add", 32'(mem_add), 32'd4);
        run = 1'b0;
        wait_empty("drain_bp");

        // Wrap-around from 31 to 0 via redirect from IDLE.
        push_exp(31); push_exp(0);
        redirect_valid = 1'b1;
        redirect_pc = 5'd31;
        run = 1'b1;
        tick();
        redirect_valid = 1'b0;
        check("wrap_add31", 32'(mem_add), 32'd31);
        wait_req(0, "wrap_req0");
        run = 1'b0;
        wait_empty("drain_wrap");

        // Redirect during WAIT: the in-flight word for pc 1 is dropped.
        push_exp(12); push_exp(13);
        run = 1'b1;
        tick();
        check("rw_req_add", 32'(mem_add), 32'd1);
        tick();
        redirect_valid = 1'b1;
        redirect_pc = 5'd12;
        tick();
        redirect_valid = 1'b0;
        check("rw_en", 32'(mem_en), 32'd1);
        check("rw_add", 32'(mem_add), 32'd12);
        check("rw_valid", 32'(instr_valid), 32'd0);
        wait_req(13, "rw_req13");
        run = 1'b0;
        wait_empty("drain_rw");

        // Redirect coincident with a transfer: held word delivered, then 12.
        push_exp(14); push_exp(12);
        instr_ready = 1'b0;
        run = 1'b1;
        wait_valid("rv_valid");
        instr_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 5'd12;
        tick();
        redirect_valid = 1'b0;
        check("rv_add", 32'(mem_add), 32'd12);
        check("rv_valid", 32'(instr_valid), 32'd0);
        run = 1'b0;
        wait_empty("drain_rv");

        // Reset while holding a word in VALID.
        instr_ready = 1'b0;
        run = 1'b1;
        wait_valid("rs_valid");
        rst = 1'b1;
        tick();
        check("rs_valid0", 32'(instr_valid), 32'd0);
        check("rs_en0", 32'(mem_en), 32'd0);
        check("rs_add0", 32'(mem_add), 32'd0);
        check("rs_instr0", 32'(instr), 32'd0);
        push_exp(0);
        rst = 1'b0;
        tick();
        check("rs_req_en", 32'(mem_en), 32'd1);
        check("rs_req_add", 32'(mem_add), 32'd0);
        instr_ready = 1'b1;
        run = 1'b0;
        wait_empty("drain_rs");

        check("q_left", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage for the 14-bit ISA datapath. Owns the program counter, issues read requests to the `memoria` program/data memory (32 × 14-bit words), and captures each returned word into an instruction register. It presents the word to the decode stage over a valid/ready handshake and accepts PC redirects from the execute stage for branches and jumps.

## Interface
- `ADDR_W`, 5: memory address and PC width (32 words).
- `DATA_W`, 14: instruction word width.
- `RESET_PC`, 0: PC value after reset.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `run`  in  1  level; enables fetching while high.
- `redirect_valid`  in  1  one-cycle pulse from execute; loads `redirect_pc`.
- `redirect_pc`  in  ADDR_W  branch/jump target.
- `mem_add`  out  ADDR_W  memory address, driven to `memoria.add`.
- `mem_en`  out  1  read request, driven to `memoria.en`.
- `mem_data`  in  DATA_W  from `memoria.data_out`, valid exactly one cycle after an `mem_en` cycle.
- `instr_valid`  out  1  instruction register holds a word for decode.
- `instr`  out  DATA_W  fetched instruction word.
- `instr_pc`  out  ADDR_W  address the word was fetched from.
- `instr_ready`  in  1  decode accepts the word this cycle.

## Operation
- **States:** IDLE, REQ, WAIT, VALID.
- **IDLE:** `mem_en`=0 and `instr_valid`=0. Go to REQ when `run`=1.
- **REQ:** `mem_en`=1 and `mem_add`=pc for exactly one cycle. Then go to WAIT.
- **WAIT:** `mem_en`=0. At the end of the cycle, capture `instr`<=`mem_data` and `instr_pc`<=pc. Then go to VALID.
- **VALID:** `instr_valid`=1, and `instr`/`instr_pc` are held stable until transfer.
  - A transfer is `instr_valid` && `instr_ready`.
  - On transfer: pc<=pc+1. Go to REQ if `run`=1, else IDLE.
- **PC arithmetic:** pc+1 is modulo 2^ADDR_W, so 31 wraps to 0. There is no overflow flag.
- **Redirect** has priority over every other transition:
  - pc<=`redirect_pc`.
  - Any in-flight or held word is discarded, and `instr_valid` is 0 in the next cycle.
  - Next state is REQ if `run`=1, else IDLE.
- **Redirect in VALID with a simultaneous transfer:** the transfer counts as completed (decode keeps the word). The PC still takes `redirect_pc`, not pc+1.
- **Redirect in WAIT:** the returning `mem_data` is not captured.
- **`run` drops mid-fetch:** the current fetch completes through VALID and transfer, then the block goes to IDLE. No new REQ is issued while `run`=0.
- **`rst`=1:** overrides everything. pc=RESET_PC, state=IDLE. Reset values: `mem_en`=0, `mem_add`=RESET_PC, `instr_valid`=0, `instr`=0, `instr_pc`=0.
- **Never writes memory:** the write path (`memoria.data_in`) is owned by the loader and is tied to 0 at this stage's boundary.

## Timing
- **Latency:** 3 cycles from entering REQ to `instr_valid` rising (REQ, WAIT, then VALID).
- **Throughput:** with `instr_ready` tied high, one instruction per 3 cycles.
- **Output timing:** `mem_add` and `mem_en` are registered outputs. `instr_valid`, `instr` and `instr_pc` are registered outputs.
- **Handshake:**
  - `instr_valid` never drops without a transfer, except on redirect or reset.
  - `instr` must not change while `instr_valid`=1 and `instr_ready`=0.
- **Redirect latency:** the new target's REQ is issued in the cycle after the `redirect_valid` pulse.
- **Reset mid-operation:** state returns to IDLE in the cycle after `rst` is sampled high, and all outputs take their reset values.

## Structure
- Shared package `isa_pkg`:
  - `ADDR_W`/`DATA_W` constants.
  - Instruction field positions: opcode [13:10], operand fields [9:0], for decode's use.
  - Fetch state enum `fetch_state_t` {IDLE, REQ, WAIT, VALID}.
- Single module. No sub-module; the PC register and incrementer are inline.
- Top-level integration wires `mem_add`/`mem_en`/`mem_data` to the `memoria` instance.

## Test plan
- **Reset then run:** memory preloaded with word[k] = 14'h1000+k, `run`=1, `instr_ready`=1 → `instr` sequence 1000, 1001, 1002 with `instr_pc` 0, 1, 2. Each word appears 3 cycles after its REQ.
- **Backpressure:** hold `instr_ready`=0 for 5 cycles in VALID → `instr` is stable at the same value. No `mem_en` pulses occur until the transfer, then pc advances by 1.
- **Wrap-around:** redirect to 31, accept → next `instr_pc` is 0 and `mem_add`=0.
- **Redirect:**
  - Pulse `redirect_valid` with `redirect_pc`=12 during WAIT → the word being fetched is dropped and the next `instr_pc` is 12.
  - Pulse simultaneous with a transfer in VALID → decode receives the held word, then `instr_pc`=12.
- **`run` drop:** deassert `run` during REQ → that word is delivered, the block goes to IDLE after the transfer, and `mem_en` stays 0 for 10 cycles. Reasserting `run` resumes at pc+1.
- **Reset mid-fetch:** assert `rst` in VALID → next cycle `instr_valid`=0, `mem_en`=0, pc=0. First fetch after release is at address 0.
